secuenciador_control: RTL and testbench
=======================================

// Module: secuenciador_control
// PURPOSE
//  Main control unit and run sequencer for the single-cycle LEGv8 datapath (Ruta_Datos).
//  Decodes opcode[10:0] into the datapath control buses and gates every state-changing strobe.
//  Strobes gated: PC enable, regWr, memWr, beq, bne.
//  Provides run / single-step / halt modes, multi-cycle LDUR wait and a retired-instruction counter.
//  Sits beside Ruta_Datos; pc_en drives the PC clock-enable input of the datapath revision.
// PARAMETERS
//  LOAD_WAIT  1   extra cycles an LDUR is held before writeback (0 = single-cycle load)
//  CNT_W      32  width of retired-instruction counter
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst          in   1      synchronous reset, active-high
//  run          in   1      level: execute continuously while high
//  step         in   1      execute exactly one instruction per rising edge (edge-detected internally)
//  halt_req     in   1      level: force HALT
//  opcode       in   11     instruction[31:21] from datapath
//  pc_en        out  1      PC advances this cycle
//  reg2loc      out  1      1 = Rm mux selects Rt (instr[4:0])
//  seu          out  2      00 ALU-imm [21:10], 01 DT [20:12], 10 CB [23:5]<<2, 11 B [25:0]<<2
//  aluSrc       out  1      1 = ALU B operand from SEU
//  aluOp        out  3      000 AND, 001 ORR, 010 ADD, 011 SUB, 100 PASS_B, 101 ZERO
//  memWr        out  1      data-memory write strobe
//  memToReg     out  1      1 = writeback from memory
//  regWr        out  1      register-file write strobe
//  beq          out  1      branch if ALU zero
//  bne          out  1      branch if ALU not zero
//  estado       out  2      00 IDLE, 01 RUN, 10 WAIT, 11 HALT
//  illegal      out  1      sticky: unsupported opcode reached execution
//  instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: estado=IDLE, pc_en/regWr/memWr/beq/bne=0, illegal=0, instr_count=0, step edge detector cleared.
//  Decode (combinational, opcode only); x = don't-care bit:
//   ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: aluSrc=0, regWr.
//   ADDI 1001000100x, SUBI 1101000100x: seu=00, aluSrc=1, regWr.
//   LDUR 11111000010: seu=01, aluSrc=1, ADD, memToReg, regWr.
//   STUR 11111000000: reg2loc=1, seu=01, aluSrc=1, ADD, memWr.
//   CBZ 10110100xxx: reg2loc=1, seu=10, PASS_B, beq.  CBNZ 10110101xxx: same with bne.
//   B 000101xxxxx: seu=11, aluOp=ZERO, beq.
//   Any other opcode is illegal; its strobes are all 0.
//  exec = (RUN, or IDLE with step edge) and decoded opcode legal.
//   Strobes = decoded value AND exec; non-strobe mux selects pass through ungated.
//  LDUR with LOAD_WAIT>0: enter WAIT; pc_en=regWr=0 for LOAD_WAIT cycles.
//   Final WAIT cycle asserts pc_en and regWr together.
//  FSM, priority rst > halt_req > illegal > step > run:
//   IDLE -> RUN on run.
//   IDLE -> one-instruction execute on step edge, then stay IDLE.
//   RUN -> IDLE when run=0 (current cycle not executed).
//   any -> HALT on halt_req; WAIT abandoned, regWr suppressed.
//   illegal opcode in exec slot -> HALT, illegal=1, PC not advanced.
//   HALT exits only via rst.
//  Step from IDLE on LDUR: passes through WAIT, returns to IDLE (not RUN).
//  instr_count increments once per cycle with pc_en=1.
// STRUCTURE
//  Package control_pkg: opcode constants/masks, aluOp and seu encodings, estado encodings.
//  Sub-module decodificador_opcode: pure combinational opcode -> control word + legal flag.
//  Top module holds FSM, WAIT counter, step edge detector, gating logic and instr_count.
// TESTING
//  rst, run=1, ADD then SUB -> pc_en=1 both cycles, regWr=1, aluOp 010/011, instr_count=2.
//  run=0, step pulse on STUR -> one cycle: memWr=1, reg2loc=1, pc_en=1, estado stays 00, count+1.
//  run=1, LDUR, LOAD_WAIT=1 -> cycle0 pc_en=0 regWr=0 estado=10; cycle1 pc_en=1 regWr=1 memToReg=1.
//  run=1, opcode 11111111111 -> pc_en=0, all strobes 0, estado=11, illegal=1; run toggles ignored until rst.
//  halt_req during LDUR WAIT -> next cycle estado=11, regWr never asserted, instr_count unchanged.
//  CBNZ then B in RUN -> bne=1 seu=10 aluOp=100; then beq=1 seu=11 aluOp=101; step held high for 5 cycles retires 0 extra in IDLE.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the LEGv8 control sequencer: opcodes, ALU/SEU selects, FSM states.
package control_pkg;

  typedef enum logic [1:0] {
    EST_IDLE = 2'b00,
    EST_RUN  = 2'b01,
    EST_WAIT = 2'b10,
    EST_HALT = 2'b11
  } estado_t;

  typedef enum logic [2:0] {
    ALU_AND    = 3'b000,
    ALU_ORR    = 3'b001,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_PASS_B = 3'b100,
    ALU_ZERO   = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    SEU_ALU_IMM = 2'b00,
    SEU_DT      = 2'b01,
    SEU_CB      = 2'b10,
    SEU_B       = 2'b11
  } seu_t;

  typedef struct packed {
    logic       reg2loc;
    logic [1:0] seu;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       beq;
    logic       bne;
  } ctrl_word_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_B    = 11'b00010100000;

  // Mask bits set to 1 are compared; 0 marks a don't-care field.
  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_IMM  = 11'b11111111110;
  localparam logic [10:0] MASK_CB   = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == (pat & mask);
  endfunction

endpackage

// File: rtl/decodificador_opcode.sv
// Pure combinational LEGv8 opcode decoder: opcode -> control word plus legal flag.
module decodificador_opcode
  import control_pkg::*;
(
  input  logic [10:0] opcode,
  output ctrl_word_t  ctrl,
  output logic        legal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the if-chain infers a latch.
    ctrl  = '0;
    legal = 1'b1;
    if (op_match(opcode, OP_ADD, MASK_FULL)) begin
      ctrl.alu_op = ALU_ADD;
      ctrl.reg_wr = 1'b1;
    end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
      ctrl.alu_op = ALU_SUB;
      ctrl.reg_wr = 1'b1;
    end else if (op_match(opcode, OP_AND, MASK_FULL)) begin
      ctrl.alu_op = ALU_AND;
      ctrl.reg_wr = 1'b1;
    end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
      ctrl.alu_op = ALU_ORR;
      ctrl.reg_wr = 1'b1;
    end else if (op_match(opcode, OP_ADDI, MASK_IMM) || op_match(opcode, OP_SUBI, MASK_IMM)) begin
      ctrl.seu     = SEU_ALU_IMM;
      ctrl.alu_src = 1'b1;
      ctrl.alu_op  = opcode[9] ? ALU_SUB : ALU_ADD;
      ctrl.reg_wr  = 1'b1;
    end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
      ctrl.seu        = SEU_DT;
      ctrl.alu_src    = 1'b1;
      ctrl.alu_op     = ALU_ADD;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg_wr     = 1'b1;
    end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
      ctrl.reg2loc = 1'b1;
      ctrl.seu     = SEU_DT;
      ctrl.alu_src = 1'b1;
      ctrl.alu_op  = ALU_ADD;
      ctrl.mem_wr  = 1'b1;
    end else if (op_match(opcode, OP_CBZ, MASK_CB) || op_match(opcode, OP_CBNZ, MASK_CB)) begin
      ctrl.reg2loc = 1'b1;
      ctrl.seu     = SEU_CB;
      ctrl.alu_op  = ALU_PASS_B;
      ctrl.beq     = ~opcode[3];
      ctrl.bne     = opcode[3];
    end else if (op_match(opcode, OP_B, MASK_B)) begin
      ctrl.seu    = SEU_B;
      ctrl.alu_op = ALU_ZERO;
      ctrl.beq    = 1'b1;
    end else begin
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/secuenciador_control.sv
// LEGv8 run sequencer: run/step/halt FSM, LDUR wait, strobe gating and retired-instruction count.
module secuenciador_control
  import control_pkg::*;
#(
  parameter int LOAD_WAIT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [10:0]      opcode,
  output logic             pc_en,
  output logic             reg2loc,
  output logic [1:0]       seu,
  output logic             aluSrc,
  output logic [2:0]       aluOp,
  output logic             memWr,
  output logic             memToReg,
  output logic             regWr,
  output logic             beq,
  output logic             bne,
  output logic [1:0]       estado,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W   = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT + 1) : 1;
  localparam bit HAS_WAIT = (LOAD_WAIT > 0);

  estado_t           est_q, est_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ret_idle_q, ret_idle_d;
  logic              illegal_q, illegal_d;
  logic              step_q;
  logic [CNT_W-1:0]  count_q;
  ctrl_word_t        dec;
  logic              legal;
  logic              step_edge;
  logic              slot;

  decodificador_opcode u_dec (
    .opcode (opcode),
    .ctrl   (dec),
    .legal  (legal)
  );

  assign step_edge = step & ~step_q;
  assign slot      = ((est_q == EST_RUN) && run) || ((est_q == EST_IDLE) && step_edge);

  assign reg2loc  = dec.reg2loc;
  assign seu      = dec.seu;
  assign aluSrc   = dec.alu_src;
  assign aluOp    = dec.alu_op;
  assign memToReg = dec.mem_to_reg;

  always_comb begin
    est_d      = est_q;
    wait_d     = wait_q;
    ret_idle_d = ret_idle_q;
    illegal_d  = illegal_q;
    pc_en      = 1'b0;
    regWr      = 1'b0;
    memWr      = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    if (rst || est_q == EST_HALT) begin
      // Nothing executes while in reset or once halted.
    end else if (halt_req) begin
      est_d = EST_HALT;
    end else if (est_q == EST_WAIT) begin
      if (wait_q == WAIT_W'(1)) begin
        pc_en = 1'b1;
        regWr = 1'b1;
        est_d = ret_idle_q ? EST_IDLE : EST_RUN;
      end else begin
        wait_d = wait_q - WAIT_W'(1);
      end
    end else if (slot && !legal) begin
      est_d     = EST_HALT;
      illegal_d = 1'b1;
    end else if (slot && HAS_WAIT && dec.mem_to_reg) begin
      // LDUR holds PC and writeback until the memory has had its extra cycles.
      est_d      = EST_WAIT;
      wait_d     = WAIT_W'(LOAD_WAIT);
      ret_idle_d = (est_q == EST_IDLE);
    end else if (slot) begin
      pc_en = 1'b1;
      regWr = dec.reg_wr;
      memWr = dec.mem_wr;
      beq   = dec.beq;
      bne   = dec.bne;
    end else if (est_q == EST_IDLE && run) begin
      est_d = EST_RUN;
    end else if (est_q == EST_RUN && !run) begin
      est_d = EST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      est_q      <= EST_IDLE;
      wait_q     <= '0;
      ret_idle_q <= 1'b0;
      illegal_q  <= 1'b0;
      step_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      est_q      <= est_d;
      wait_q     <= wait_d;
      ret_idle_q <= ret_idle_d;
      illegal_q  <= illegal_d;
      step_q     <= step;
      if (pc_en) count_q <= count_q + CNT_W'(1);
    end
  end

  assign estado      = est_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_secuenciador_control.sv
// Self-checking bench for secuenciador_control: directed scenarios plus random traffic vs a reference model.
module tb_secuenciador_control;

  localparam int LW = 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1, run = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic [10:0] opcode = 11'b0;
  logic        pc_en, reg2loc, aluSrc, memWr, memToReg, regWr, beq, bne, illegal;
  logic [1:0]  seu, estado;
  logic [2:0]  aluOp;
  logic [31:0] instr_count;

  secuenciador_control #(.LOAD_WAIT(LW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req), .opcode(opcode),
    .pc_en(pc_en), .reg2loc(reg2loc), .seu(seu), .aluSrc(aluSrc), .aluOp(aluOp),
    .memWr(memWr), .memToReg(memToReg), .regWr(regWr), .beq(beq), .bne(bne),
    .estado(estado), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Reference decode straight from the opcode table:
  // {legal, reg2loc, seu[1:0], aluSrc, aluOp[2:0], memWr, memToReg, regWr, beq, bne}
  function automatic logic [12:0] ref_decode(input logic [10:0] op);
    if (op ==? 11'b10001011000) return 13'b1_0_00_0_010_00100;
    if (op ==? 11'b11001011000) return 13'b1_0_00_0_011_00100;
    if (op ==? 11'b10001010000) return 13'b1_0_00_0_000_00100;
    if (op ==? 11'b10101010000) return 13'b1_0_00_0_001_00100;
    if (op ==? 11'b1001000100?) return 13'b1_0_00_1_010_00100;
    if (op ==? 11'b1101000100?) return 13'b1_0_00_1_011_00100;
    if (op ==? 11'b11111000010) return 13'b1_0_01_1_010_01100;
    if (op ==? 11'b11111000000) return 13'b1_1_01_1_010_10000;
    if (op ==? 11'b10110100???) return 13'b1_1_10_0_100_00010;
    if (op ==? 11'b10110101???) return 13'b1_1_10_0_100_00001;
    if (op ==? 11'b000101?????) return 13'b1_0_11_0_101_00010;
    return 13'b0;
  endfunction

  // Model state: mode, load cycles still to wait, where a load returns, sticky illegal, count.
  int          m_mode = M_IDLE, m_wait = 0;
  bit          m_ret_idle = 0, m_ill = 0, m_prev_step = 0;
  logic [31:0] m_cnt = 0;
  int          n_mode, n_wait;
  bit          n_ret_idle, n_ill;
  bit          e_pc, e_regwr, e_memwr, e_beq, e_bne;
  logic [7:0]  e_sel;

  task automatic model_eval();
    logic [12:0] d;
    bit sedge, exec_slot;
    d = ref_decode(opcode);
    sedge = step && !m_prev_step;
    e_sel = {d[11:5], d[3]};
    {e_pc, e_regwr, e_memwr, e_beq, e_bne} = '0;
    n_mode = m_mode; n_wait = m_wait; n_ret_idle = m_ret_idle; n_ill = m_ill;
    if (rst) begin
      n_mode = M_IDLE; n_wait = 0; n_ret_idle = 0; n_ill = 0;
    end else if (m_mode == M_HALT) begin
      n_mode = M_HALT;
    end else if (halt_req) begin
      n_mode = M_HALT;
    end else if (m_mode == M_WAIT) begin
      if (m_wait == 1) begin
        e_pc = 1; e_regwr = 1;
        n_mode = m_ret_idle ? M_IDLE : M_RUN;
      end else n_wait = m_wait - 1;
    end else begin
      exec_slot = (m_mode == M_RUN && run) || (m_mode == M_IDLE && sedge);
      if (exec_slot) begin
        if (!d[12]) begin
          n_mode = M_HALT; n_ill = 1;
        end else if (LW > 0 && d[3]) begin
          n_mode = M_WAIT; n_wait = LW; n_ret_idle = (m_mode == M_IDLE);
        end else begin
          e_pc = 1; e_memwr = d[4]; e_regwr = d[2]; e_beq = d[1]; e_bne = d[0];
        end
      end else if (m_mode == M_IDLE && run) n_mode = M_RUN;
      else if (m_mode == M_RUN && !run) n_mode = M_IDLE;
    end
  endtask

  // One clock: compare every output against the model mid-cycle, then advance the model.
  task automatic tick();
    @(negedge clk);
    model_eval();
    check("pc_en", 32'(pc_en), 32'(e_pc));
    check("strobes", 32'({regWr, memWr, beq, bne}), 32'({e_regwr, e_memwr, e_beq, e_bne}));
    check("selects", 32'({reg2loc, seu, aluSrc, aluOp, memToReg}), 32'(e_sel));
    check("estado", 32'(estado), 32'(m_mode));
    check("illegal", 32'(illegal), 32'(m_ill));
    check("instr_count", instr_count, m_cnt);
    @(posedge clk);
    m_cnt       = rst ? 32'd0 : m_cnt + 32'(e_pc);
    m_prev_step = rst ? 1'b0 : step;
    m_mode = n_mode; m_wait = n_wait; m_ret_idle = n_ret_idle; m_ill = n_ill;
    #1;
  endtask

  logic [10:0] op_tab [12] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                               11'b10010001001, 11'b11010001000, 11'b11111000010, 11'b11111000000,
                               11'b10110100101, 11'b10110101011, 11'b00010111011, 11'b11111111111};

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // RUN: first cycle leaves IDLE, then ADD and SUB retire.
    run = 1'b1; opcode = 11'b10001011000;
    tick();
    #1 check("add_aluop", 32'(aluOp), 32'd2);
    tick();
    opcode = 11'b11001011000;
    #1 check("sub_aluop", 32'(aluOp), 32'd3);
    tick();
    check("count_after_add_sub", instr_count, 32'd2);

    // Single step on STUR from IDLE.
    run = 1'b0;
    tick();
    opcode = 11'b11111000000; step = 1'b1;
    #1 check("stur_step", 32'({memWr, reg2loc, pc_en}), 32'b111);
    tick();
    check("stur_stays_idle", 32'(estado), 32'd0);
    check("count_after_stur", instr_count, 32'd3);
    step = 1'b0;
    tick();

    // LDUR with one wait cycle.
    run = 1'b1; opcode = 11'b11111000010;
    tick();
    #1 check("ldur_cycle0", 32'({pc_en, regWr}), 32'b00);
    tick();
    check("ldur_wait_state", 32'(estado), 32'd2);
    #1 check("ldur_cycle1", 32'({pc_en, regWr, memToReg}), 32'b111);
    tick();
    check("count_after_ldur", instr_count, 32'd4);

    // CBNZ then B.
    opcode = 11'b10110101000;
    #1 check("cbnz_ctrl", 32'({bne, seu, aluOp}), 32'b1_10_100);
    tick();
    opcode = 11'b00010100000;
    #1 check("b_ctrl", 32'({beq, seu, aluOp}), 32'b1_11_101);
    tick();

    // Step held high for five cycles retires exactly one instruction.
    run = 1'b0; opcode = 11'b10001011000;
    tick();
    step = 1'b1;
    repeat (5) tick();
    step = 1'b0;
    check("count_after_held_step", instr_count, 32'd7);

    // halt_req during the LDUR wait.
    run = 1'b1; opcode = 11'b11111000010;
    repeat (2) tick();
    halt_req = 1'b1;
    #1 check("halt_no_regwr", 32'(regWr), 32'd0);
    tick();
    halt_req = 1'b0;
    check("halt_state", 32'(estado), 32'd3);
    check("halt_count", instr_count, 32'd7);

    // Illegal opcode halts and sets the sticky flag; run toggles are ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0; run = 1'b1; opcode = 11'b11111111111;
    repeat (2) tick();
    check("illegal_state", 32'({estado, illegal}), 32'b11_1);
    run = 1'b0; tick();
    run = 1'b1; tick();
    check("illegal_stays_halted", 32'(estado), 32'd3);

    // Randomised episodes, each starting from reset.
    for (int ep = 0; ep < 24; ep++) begin
      rst = 1'b1; halt_req = 1'b0; step = 1'b0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 80; c++) begin
        run      = ($urandom_range(0, 99) < 85);
        step     = ($urandom_range(0, 3) == 0);
        halt_req = ($urandom_range(0, 59) == 0);
        rst      = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 15) == 0) opcode = 11'($urandom);
        else if ($urandom_range(0, 24) == 0) opcode = op_tab[11];
        else opcode = op_tab[$urandom_range(0, 10)];
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
